// File: rtl/i2s_adc_rx.sv
// -----------------------------------------------------------------------------
// i2s_adc_rx
//
// Serial-to-parallel receiver for the WM8731 ADC path in I2S mode. Runs on the
// codec bit clock, frames ADCDAT with ADCLRCK and assembles signed left/right
// sample pairs for the downstream processing stage.
//
// Ports:
//   i_clk        codec bit clock (AUD_BCLK), rising edge
//   i_rst_n      asynchronous active-low reset
//   i_adclrck    LR clock: 0 = left half-frame, 1 = right half-frame
//   i_adcdat     serial data, MSB first, one BCLK after each LRCK edge
//   i_ready      downstream ready
//   o_left       left sample (two's complement)
//   o_right      right sample (two's complement)
//   o_valid      pair available
//   o_overrun    one-cycle pulse: a completed pair was dropped
//   o_frame_err  one-cycle pulse: a half-frame ended before DATA_W bits
//   o_dbg_state  current FSM state (0 = SYNC, 1 = SHIFT, 2 = WAIT)
//
// Handshake: a pair transfers on every rising edge where o_valid && i_ready.
// Once o_valid is high, o_left/o_right/o_valid stay unchanged until that
// transfer; o_valid never depends combinationally on i_ready.
// -----------------------------------------------------------------------------
module i2s_adc_rx #(
    parameter int DATA_W = 16
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_adclrck,
    input  logic              i_adcdat,
    input  logic              i_ready,
    output logic [DATA_W-1:0] o_left,
    output logic [DATA_W-1:0] o_right,
    output logic              o_valid,
    output logic              o_overrun,
    output logic              o_frame_err,
    output logic [1:0]        o_dbg_state
);

    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        ST_SYNC  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               lrck_q;
    logic               chan_q, chan_d;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0]  shreg_q, shreg_d;
    logic [DATA_W-1:0]  left_hold_q, left_hold_d;
    logic               left_ok_q, left_ok_d;
    logic [DATA_W-1:0]  left_q, left_d;
    logic [DATA_W-1:0]  right_q, right_d;
    logic               valid_q, valid_d;
    logic               overrun_q, overrun_d;
    logic               ferr_q, ferr_d;

    logic               lr_edge;
    logic               word_done;
    logic [DATA_W-1:0]  word_val;
    logic               pair_fire;

    assign lr_edge  = (i_adclrck != lrck_q);
    // The bit on the wire this cycle completes the word when it is the LSB.
    assign word_val = {shreg_q[DATA_W-2:0], i_adcdat};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= ST_SYNC;
            lrck_q      <= 1'b0;
            chan_q      <= 1'b0;
            bit_cnt_q   <= '0;
            shreg_q     <= '0;
            left_hold_q <= '0;
            left_ok_q   <= 1'b0;
            left_q      <= '0;
            right_q     <= '0;
            valid_q     <= 1'b0;
            overrun_q   <= 1'b0;
            ferr_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            lrck_q      <= i_adclrck;
            chan_q      <= chan_d;
            bit_cnt_q   <= bit_cnt_d;
            shreg_q     <= shreg_d;
            left_hold_q <= left_hold_d;
            left_ok_q   <= left_ok_d;
            left_q      <= left_d;
            right_q     <= right_d;
            valid_q     <= valid_d;
            overrun_q   <= overrun_d;
            ferr_q      <= ferr_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        chan_d      = chan_q;
        bit_cnt_d   = bit_cnt_q;
        shreg_d     = shreg_q;
        left_hold_d = left_hold_q;
        left_ok_d   = left_ok_q;
        left_d      = left_q;
        right_d     = right_q;
        valid_d     = valid_q;
        overrun_d   = 1'b0;
        ferr_d      = 1'b0;
        word_done   = 1'b0;
        pair_fire   = 1'b0;

        case (state_q)
            ST_SYNC: begin
                // The bit seen in the edge cycle belongs to the previous
                // (unseen) word, so collection starts on the next cycle.
                if (lr_edge) begin
                    state_d   = ST_SHIFT;
                    chan_d    = i_adclrck;
                    bit_cnt_d = '0;
                end
            end
            ST_SHIFT: begin
                shreg_d = word_val;
                if (bit_cnt_q == LAST_BIT) begin
                    word_done = 1'b1;
                    state_d   = ST_WAIT;
                    bit_cnt_d = '0;
                end else begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
                // With a 32*fs BCLK the LSB lands exactly in the edge cycle:
                // the word still completes and the next one starts at once.
                if (lr_edge) begin
                    if (bit_cnt_q != LAST_BIT) begin
                        ferr_d = 1'b1;
                    end
                    state_d   = ST_SHIFT;
                    chan_d    = i_adclrck;
                    bit_cnt_d = '0;
                end
            end
            ST_WAIT: begin
                if (lr_edge) begin
                    state_d   = ST_SHIFT;
                    chan_d    = i_adclrck;
                    bit_cnt_d = '0;
                end
            end
            default: begin
                state_d = ST_SYNC;
            end
        endcase

        // Pairing: a right word only forms a pair if a complete left word
        // precedes it; otherwise it is the partial frame after sync/error.
        if (word_done) begin
            if (!chan_q) begin
                left_hold_d = word_val;
                left_ok_d   = 1'b1;
            end else if (left_ok_q) begin
                pair_fire = 1'b1;
                left_ok_d = 1'b0;
            end
        end
        if (ferr_d) begin
            left_ok_d = 1'b0;
        end

        if (valid_q && i_ready) begin
            valid_d = 1'b0;
        end
        if (pair_fire) begin
            if (!valid_q || i_ready) begin
                left_d  = left_hold_q;
                right_d = word_val;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    assign o_left      = left_q;
    assign o_right     = right_q;
    assign o_valid     = valid_q;
    assign o_overrun   = overrun_q;
    assign o_frame_err = ferr_q;
    assign o_dbg_state = state_q;

endmodule

// File: tb/tb_i2s_adc_rx.sv
// -----------------------------------------------------------------------------
// tb_i2s_adc_rx
//
// Directed bench for i2s_adc_rx (DATA_W = 16). Half-frames are generated bit by
// bit; every BCLK cycle the bench states whether a pair load, an overrun pulse
// or a frame-error pulse must be visible after that edge, and checks it.
// -----------------------------------------------------------------------------
module tb_i2s_adc_rx;

    localparam int DW = 16;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          i_adclrck;
    logic          i_adcdat;
    logic          i_ready;
    logic [DW-1:0] o_left;
    logic [DW-1:0] o_right;
    logic          o_valid;
    logic          o_overrun;
    logic          o_frame_err;
    logic [1:0]    o_dbg_state;

    i2s_adc_rx #(.DATA_W(DW)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_adclrck   (i_adclrck),
        .i_adcdat    (i_adcdat),
        .i_ready     (i_ready),
        .o_left      (o_left),
        .o_right     (o_right),
        .o_valid     (o_valid),
        .o_overrun   (o_overrun),
        .o_frame_err (o_frame_err),
        .o_dbg_state (o_dbg_state)
    );

    // ---------------- scoreboard state ----------------
    int              n_tests = 0;
    int              n_fail  = 0;
    logic [2*DW-1:0] exp_q[$];
    logic            pv;           // o_valid seen after previous edge
    logic [DW-1:0]   pl, pr;       // outputs seen after previous edge
    // Bit (and its expected side effects) that falls on the next edge cycle.
    logic            c_bit, c_ld, c_ovr, c_ferr;

    typedef struct {
        logic [DW-1:0] left;
        logic [DW-1:0] right;
        int            len;
        logic [DW-1:0] exp_left;
        logic [DW-1:0] exp_right;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One BCLK cycle: drive, take the rising edge, check what that edge did.
    task automatic tick(input logic lr, input logic dat, input logic ld,
                        input logic ovr, input logic ferr);
        logic            rdy_edge;
        logic            load_seen;
        logic [2*DW-1:0] e;
        i_adclrck = lr;
        i_adcdat  = dat;
        rdy_edge  = i_ready;
        @(posedge clk);
        #1;
        load_seen = o_valid && (!pv || rdy_edge);
        if (ld) begin
            chk("load", 64'(load_seen), 64'(1'b1));
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("pair", 64'({o_left, o_right}), 64'(e));
            end else begin
                chk("exp_q_nonempty", 64'(0), 64'(1));
            end
        end else begin
            chk("no_load", 64'(load_seen), 64'(1'b0));
            if (pv && !rdy_edge) begin
                chk("valid_held", 64'(o_valid), 64'(1'b1));
                chk("pair_held", 64'({o_left, o_right}), 64'({pl, pr}));
            end
        end
        chk("overrun", 64'(o_overrun), 64'(ovr));
        chk("frame_err", 64'(o_frame_err), 64'(ferr));
        pv = o_valid;
        pl = o_left;
        pr = o_right;
    endtask

    // One half-frame of len BCLK cycles on channel ch carrying word w.
    // Position 0 is the edge cycle (previous word's carried LSB), positions
    // 1..DW carry w MSB first; a position DW that falls past len lands on the
    // next half's edge cycle. ld/ovr describe what w's LSB must cause.
    task automatic send_half(input logic ch, input logic [DW-1:0] w, input int len,
                             input logic ld, input logic ovr, input logic set_rdy,
                             input logic [2*DW-1:0] pair);
        if (ld) exp_q.push_back(pair);
        for (int k = 0; k < len; k++) begin
            if (k == 0) begin
                tick(ch, c_bit, c_ld, c_ovr, c_ferr);
            end else if (k < DW) begin
                tick(ch, w[DW-k], 1'b0, 1'b0, 1'b0);
            end else if (k == DW) begin
                if (set_rdy) i_ready = 1'b1;
                tick(ch, w[0], ld, ovr, 1'b0);
            end else begin
                tick(ch, 1'b0, 1'b0, 1'b0, 1'b0);
            end
        end
        if (len == DW) begin
            c_bit = w[0]; c_ld = ld; c_ovr = ovr; c_ferr = 1'b0;
        end else if (len < DW) begin
            c_bit = w[DW-len]; c_ld = 1'b0; c_ovr = 1'b0; c_ferr = 1'b1;
        end else begin
            c_bit = 1'b0; c_ld = 1'b0; c_ovr = 1'b0; c_ferr = 1'b0;
        end
    endtask

    initial begin
        // ---------------- reset ----------------
        rst_n = 1'b0; i_adclrck = 1'b0; i_adcdat = 1'b0; i_ready = 1'b1;
        pv = 1'b0; pl = '0; pr = '0;
        c_bit = 1'b0; c_ld = 1'b0; c_ovr = 1'b0; c_ferr = 1'b0;

        vecs[0] = '{16'h8001, 16'h7FFE, 16, 16'h8001, 16'h7FFE};
        vecs[1] = '{16'h8001, 16'h7FFE, 16, 16'h8001, 16'h7FFE};
        vecs[2] = '{16'h8001, 16'h7FFE, 16, 16'h8001, 16'h7FFE};
        vecs[3] = '{16'hFFFF, 16'h0000, 16, 16'hFFFF, 16'h0000};
        vecs[4] = '{16'h1234, 16'hABCD, 32, 16'h1234, 16'hABCD};
        vecs[5] = '{16'h8000, 16'h7FFF, 32, 16'h8000, 16'h7FFF};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_left", 64'(o_left), 64'(0));
        chk("rst_right", 64'(o_right), 64'(0));
        chk("rst_valid", 64'(o_valid), 64'(0));
        chk("rst_overrun", 64'(o_overrun), 64'(0));
        chk("rst_frame_err", 64'(o_frame_err), 64'(0));
        chk("rst_state", 64'(o_dbg_state), 64'(0));
        rst_n = 1'b1;
        repeat (3) tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Initial partial frame: a right word with no left before it.
        send_half(1'b1, 16'hFFFF, 16, 1'b0, 1'b0, 1'b0, '0);

        // ---------------- table-driven frames, i_ready = 1 ----------------
        for (int i = 0; i < 6; i++) begin
            send_half(1'b0, vecs[i].left, vecs[i].len, 1'b0, 1'b0, 1'b0, '0);
            send_half(1'b1, vecs[i].right, vecs[i].len, 1'b1, 1'b0, 1'b0,
                      {vecs[i].exp_left, vecs[i].exp_right});
        end

        // ---------------- backpressure: hold and overrun ----------------
        i_ready = 1'b0;
        send_half(1'b0, 16'h0102, 32, 1'b0, 1'b0, 1'b0, '0);
        send_half(1'b1, 16'h0304, 32, 1'b1, 1'b0, 1'b0, {16'h0102, 16'h0304});
        send_half(1'b0, 16'h0506, 32, 1'b0, 1'b0, 1'b0, '0);
        send_half(1'b1, 16'h0708, 32, 1'b0, 1'b1, 1'b0, '0);
        repeat (3) tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("held_left", 64'(o_left), 64'(16'h0102));
        chk("held_right", 64'(o_right), 64'(16'h0304));
        chk("held_valid", 64'(o_valid), 64'(1));
        i_ready = 1'b1;
        tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("valid_drop", 64'(o_valid), 64'(0));
        tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        // ---------------- accept and load in the same cycle ----------------
        i_ready = 1'b0;
        send_half(1'b0, 16'h0A0B, 32, 1'b0, 1'b0, 1'b0, '0);
        send_half(1'b1, 16'h0C0D, 32, 1'b1, 1'b0, 1'b0, {16'h0A0B, 16'h0C0D});
        send_half(1'b0, 16'h0E0F, 32, 1'b0, 1'b0, 1'b0, '0);
        send_half(1'b1, 16'h1011, 32, 1'b1, 1'b0, 1'b1, {16'h0E0F, 16'h1011});

        // ---------------- truncated left half-frame ----------------
        i_ready = 1'b1;
        send_half(1'b0, 16'h1111, 10, 1'b0, 1'b0, 1'b0, '0);
        send_half(1'b1, 16'h2222, 16, 1'b0, 1'b0, 1'b0, '0);
        send_half(1'b0, 16'h3333, 16, 1'b0, 1'b0, 1'b0, '0);
        send_half(1'b1, 16'h4444, 16, 1'b1, 1'b0, 1'b0, {16'h3333, 16'h4444});
        send_half(1'b0, 16'h5555, 32, 1'b0, 1'b0, 1'b0, '0);

        // ---------------- reset in the middle of a right word ----------------
        i_ready = 1'b0;
        send_half(1'b1, 16'h2468, 32, 1'b1, 1'b0, 1'b0, {16'h5555, 16'h2468});
        send_half(1'b0, 16'h6666, 32, 1'b0, 1'b0, 1'b0, '0);
        tick(1'b1, c_bit, c_ld, c_ovr, c_ferr);
        for (int k = 1; k <= 8; k++) tick(1'b1, k[0], 1'b0, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_left", 64'(o_left), 64'(0));
        chk("async_rst_right", 64'(o_right), 64'(0));
        chk("async_rst_valid", 64'(o_valid), 64'(0));
        chk("async_rst_overrun", 64'(o_overrun), 64'(0));
        chk("async_rst_frame_err", 64'(o_frame_err), 64'(0));
        pv = 1'b0;
        repeat (3) tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        i_ready = 1'b1;
        // Rest of the right half: collected after release but never paired.
        for (int k = 0; k < 40; k++) tick(1'b1, k[0], 1'b0, 1'b0, 1'b0);
        chk("post_rst_no_pair", 64'(o_valid), 64'(0));
        c_bit = 1'b0; c_ld = 1'b0; c_ovr = 1'b0; c_ferr = 1'b0;
        send_half(1'b0, 16'h9ABC, 32, 1'b0, 1'b0, 1'b0, '0);
        send_half(1'b1, 16'hDEF0, 32, 1'b1, 1'b0, 1'b0, {16'h9ABC, 16'hDEF0});
        repeat (2) tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("exp_q_drained", 64'(exp_q.size()), 64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
